// File: rtl/fetch_queue_if.sv
// Fetch queue bus: the cache-side fetch bundle, the decode-side view and
// consume count, and the occupancy.
//   master : drives in_valid/in_pc/in_inst0..3/deq_num (fetch + decode side)
//   slave  : drives in_ready/out_inst0..3/out_pc0..3/count (the queue)
interface fetch_queue_if #(
  parameter int PTR_W = 4
);
  logic             in_valid;
  logic [31:0]      in_pc;
  logic [32:0]      in_inst0;
  logic [32:0]      in_inst1;
  logic [32:0]      in_inst2;
  logic [32:0]      in_inst3;
  logic             in_ready;
  logic [32:0]      out_inst0;
  logic [32:0]      out_inst1;
  logic [32:0]      out_inst2;
  logic [32:0]      out_inst3;
  logic [31:0]      out_pc0;
  logic [31:0]      out_pc1;
  logic [31:0]      out_pc2;
  logic [31:0]      out_pc3;
  logic [2:0]       deq_num;
  logic [PTR_W:0]   count;

  modport master (
    output in_valid, in_pc, in_inst0, in_inst1, in_inst2, in_inst3, deq_num,
    input  in_ready, out_inst0, out_inst1, out_inst2, out_inst3,
           out_pc0, out_pc1, out_pc2, out_pc3, count
  );

  modport slave (
    input  in_valid, in_pc, in_inst0, in_inst1, in_inst2, in_inst3, deq_num,
    output in_ready, out_inst0, out_inst1, out_inst2, out_inst3,
           out_pc0, out_pc1, out_pc2, out_pc3, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue between the instruction cache and decode.
// Absorbs up to four leading-valid slots per cycle into a circular buffer
// and presents the four oldest entries (with PCs) to decode, which consumes
// 0..4 per cycle.
// Ports:
//   clk    : clock, all state updates on posedge
//   resetn : synchronous active-low reset
//   flush  : redirect; empties the queue, drops same-cycle enq/deq
//   fq     : fetch_queue_if.slave (fetch bundle, decode view, deq_num, count)
module fetch_queue #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         flush,
  fetch_queue_if.slave fq
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count_q;

  logic [3:0]       slot_vld;
  logic [31:0]      slot_inst [4];
  logic [2:0]       enq_n;
  logic [2:0]       enq_eff;
  logic [2:0]       deq_cap;
  logic [2:0]       deq_eff;
  logic [PTR_W:0]   free_slots;
  logic             in_ready;
  logic             enq_fire;
  logic [32:0]      out_inst [4];
  logic [31:0]      out_pc   [4];

  assign slot_vld     = {fq.in_inst3[32], fq.in_inst2[32], fq.in_inst1[32], fq.in_inst0[32]};
  assign slot_inst[0] = fq.in_inst0[31:0];
  assign slot_inst[1] = fq.in_inst1[31:0];
  assign slot_inst[2] = fq.in_inst2[31:0];
  assign slot_inst[3] = fq.in_inst3[31:0];

  // Only the leading run of valid slots is taken; anything after a hole is dropped.
  always_comb begin
    enq_n = 3'd0;
    casez (slot_vld)
      4'b1111: enq_n = 3'd4;
      4'b0111: enq_n = 3'd3;
      4'b?011: enq_n = 3'd2;
      4'b??01: enq_n = 3'd1;
      default: enq_n = 3'd0;
    endcase
  end

  // Ready depends on registered occupancy only, so a same-cycle dequeue
  // never opens room for the same-cycle bundle.
  assign free_slots = DEPTH_CNT - count_q;
  assign in_ready   = free_slots >= (PTR_W+1)'(4);
  assign enq_fire   = fq.in_valid & in_ready & ~flush & (enq_n != 3'd0);
  assign enq_eff    = enq_fire ? enq_n : 3'd0;

  assign deq_cap = (fq.deq_num > 3'd4) ? 3'd4 : fq.deq_num;
  assign deq_eff = ((PTR_W+1)'(deq_cap) > count_q) ? count_q[2:0] : deq_cap;

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      head    <= head + PTR_W'(deq_eff);
      tail    <= tail + PTR_W'(enq_eff);
      count_q <= count_q + (PTR_W+1)'(enq_eff) - (PTR_W+1)'(deq_eff);
    end
  end

  // Storage has no reset; entries beyond count are never shown.
  always_ff @(posedge clk) begin
    if (resetn && enq_fire) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < enq_n) begin
          pc_mem[tail + PTR_W'(k)]   <= fq.in_pc + 32'(4 * k);
          inst_mem[tail + PTR_W'(k)] <= slot_inst[k];
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      out_inst[k] = 33'd0;
      out_pc[k]   = 32'd0;
      if (count_q > (PTR_W+1)'(k)) begin
        out_inst[k] = {1'b1, inst_mem[head + PTR_W'(k)]};
        out_pc[k]   = pc_mem[head + PTR_W'(k)];
      end
    end
  end

  assign fq.in_ready  = in_ready;
  assign fq.count     = count_q;
  assign fq.out_inst0 = out_inst[0];
  assign fq.out_inst1 = out_inst[1];
  assign fq.out_inst2 = out_inst[2];
  assign fq.out_inst3 = out_inst[3];
  assign fq.out_pc0   = out_pc[0];
  assign fq.out_pc1   = out_pc[1];
  assign fq.out_pc2   = out_pc[2];
  assign fq.out_pc3   = out_pc[3];

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch queue sitting directly downstream of the instruction cache.
- Accepts up to four {valid, inst} 33-bit slots per cycle from the cache fetch output, together with the PC of slot 0.
- Buffers them in a circular FIFO and presents up to four oldest instructions, with their PCs, to decode.
- Decouples cache hit/miss timing from decode consumption; cleared by a redirect flush.

Parameters:
- DEPTH, 16, number of entries; power of two, minimum 8.
- PTR_W, 4, log2(DEPTH); width of head/tail pointers.

Ports:
- clk  input  1  clock; all state updates on posedge.
- resetn  input  1  synchronous, active-low reset.
- flush  input  1  branch/exception redirect; discards all queued and incoming instructions.
- in_valid  input  1  fetch bundle present this cycle.
- in_pc  input  32  PC of in_inst0; slot k has PC in_pc + 4*k.
- in_inst0..in_inst3  input  33 each  bit 32 = slot valid, bits 31:0 = instruction.
- in_ready  output  1  queue can absorb a full 4-slot bundle.
- out_inst0..out_inst3  output  33 each  bit 32 = valid, bits 31:0 = instruction at head+k.
- out_pc0..out_pc3  output  32 each  PC of out_instk.
- deq_num  input  3  number of instructions decode consumes this cycle, 0..4.
- count  output  PTR_W+1  current occupancy.

Behaviour:
- Storage: DEPTH entries of {pc[31:0], inst[31:0]}; head, tail pointers PTR_W bits; count PTR_W+1 bits.
- Pointers wrap modulo DEPTH. Full/empty are taken from count, never from pointer equality.
- Reset (resetn=0 at posedge): head=0, tail=0, count=0. Storage contents are don't-care.
- After reset: in_ready=1, count=0, all out_instk=33'd0, out_pck=32'd0.
- Enqueue count n = number of leading set valid bits starting at slot 0:
  - slot0 invalid -> n=0.
  - 1,1,0,1 -> n=2; valid bits after the first zero are ignored.
- Enqueue fires when in_valid & in_ready & ~flush & n>0.
  - Entry tail+k gets {in_pc + 4*k, in_instk[31:0]} for k<n.
  - tail advances by n.
- in_ready = (DEPTH - count) >= 4.
  - Combinational from registered count only; no path from deq_num or in_* to in_ready.
  - When in_valid=1 and in_ready=0, the bundle is not taken. Upstream must hold it.
- Output view is combinational from registered state:
  - out_instk = {1'b1, inst[head+k]} and out_pck = pc[head+k] when count > k.
  - Otherwise out_instk = 33'd0 and out_pck = 32'd0.
  - Zero-latency read: an entry enqueued at edge t is visible on the outputs during the cycle after t.
- Dequeue: effective d = min(deq_num, count, 4). head advances by d.
  - deq_num greater than count is clamped, not an error.
  - Values 5..7 are treated as 4, then clamped.
- Simultaneous enqueue and dequeue: count_next = count + n - d. Both pointer updates happen in the same edge.
- Dequeue never frees space for the same cycle's enqueue decision (in_ready uses pre-update count).
- flush=1 at posedge: head=0, tail=0, count=0. Same-cycle enqueue and dequeue are discarded.
  - flush has priority over everything except reset.
- Reset mid-operation behaves identically to flush.
- Invariant: 0 <= count <= DEPTH at all times; count never exceeds DEPTH because in_ready guarantees 4 free slots.

Test Plan:
1. Reset, then enqueue in_pc=0x1000 with four valid slots 0xA0..0xA3 -> next cycle count=4; out_inst0..3 = {1,0xA0..0xA3}; out_pc0..3 = 0x1000, 0x1004, 0x1008, 0x100C.
2. Enqueue bundle with valid bits 1,1,0,1 (pc 0x2000), deq_num=0 -> count=2; out_inst2 = 33'd0; out_pc1 = 0x2004.
3. Fill to count=13 -> in_ready=0; offered bundle ignored and count stays 13; deq_num=1 -> count 12, in_ready=1 next cycle.
4. Wrap-around: run 40 cycles of 4-in/4-out with incrementing PCs -> outputs strictly in program order across pointer wrap; count stays 4.
5. count=2 with deq_num=4 and a 3-valid enqueue in the same cycle -> count_next=3; head advanced by 2; out_inst0 = first new instruction.
6. count=10 with flush=1 plus a simultaneous valid enqueue and deq_num=2 -> count=0, all out valid bits 0, in_ready=1 next cycle; same test repeated with resetn=0 gives identical result.
